// File: rtl/brick_collision_if.sv
// brick_collision_if
//   Frame-level link between the ball datapath and the collision engine.
//
//   Handshake: there is no valid/ready pair on this link. A falling edge
//   on vsync acts as "valid" for ball_x/ball_y/paddle_x; they are sampled
//   on the clock edge that first sees vsync low after it was high, and
//   must be stable at that edge. The engine is always ready in IDLE; it
//   ignores vsync edges while a scan is in flight. h_collision and
//   v_collision are single-cycle pulses that the consumer must act on in
//   the cycle they are high. They are never high together.
//
//   Signals:
//     vsync       frame sync, active high (master -> slave)
//     ball_x      ball centre x, 10 bits (master -> slave)
//     ball_y      ball centre y, 10 bits (master -> slave)
//     paddle_x    paddle left edge, 10 bits (master -> slave)
//     h_collision reverse-x pulse (slave -> master)
//     v_collision reverse-y pulse (slave -> master)
interface brick_collision_if;
    logic       vsync;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_x;
    logic       h_collision;
    logic       v_collision;

    modport master (
        output vsync, ball_x, ball_y, paddle_x,
        input  h_collision, v_collision
    );

    modport slave (
        input  vsync, ball_x, ball_y, paddle_x,
        output h_collision, v_collision
    );
endinterface

// File: rtl/brick_collision.sv
// brick_collision
//   Per-frame collision engine. After each vsync falling edge it latches
//   the ball and paddle positions, walks the brick wall one brick per
//   cycle, checks the paddle, then issues at most one collision pulse and
//   removes the first brick hit.
//
//   Optional feature macro: BRICK_SCORE_EN. When defined, each removed
//   brick adds row points (top row worth ROWS, bottom row worth 1) to a
//   saturating 8-bit score. When undefined, score is tied to zero.
//
//   Ports:
//     pxl_clk      pixel clock
//     reset_n      asynchronous active-low reset
//     new_game     synchronous wall restore, overrides everything but reset
//     bus          brick_collision_if.slave: vsync, ball/paddle positions
//                  in; h_collision / v_collision pulses out
//     brick_map    bit r*COLS+c set = brick present
//     score        accumulated points
//     bricks_left  remaining bricks
//     all_cleared  high while bricks_left == 0
//     fsm_state    current FSM state (0 IDLE, 1 SCAN, 2 PADDLE, 3 HIT)
module brick_collision #(
    parameter int BRICK_X0 = 64,
    parameter int BRICK_Y0 = 48,
    parameter int BRICK_W  = 64,
    parameter int BRICK_H  = 16,
    parameter int COLS     = 8,
    parameter int ROWS     = 4,
    parameter int PADDLE_Y = 440,
    parameter int PADDLE_W = 64,
    parameter int PADDLE_H = 8
) (
    input  logic                    pxl_clk,
    input  logic                    reset_n,
    input  logic                    new_game,
    brick_collision_if.slave        bus,
    output logic [31:0]             brick_map,
    output logic [7:0]              score,
    output logic [5:0]              bricks_left,
    output logic                    all_cleared,
    output logic [1:0]              fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        PADDLE = 2'd2,
        HIT    = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic        vsync_d;
    logic        vsync_fall;
    logic [10:0] bx_l, by_l, px_l;   // latched positions, zero-extended
    logic [10:0] prev_y;
    logic [4:0]  idx_q, col_q, row_q;
    logic        hit_found, hit_h, paddle_hit;
    logic [4:0]  hit_idx;
    logic        h_q, v_q;

    // Geometry, all 11-bit unsigned and built from additions only so the
    // ball box never underflows near the screen edges.
    logic [10:0] brick_x, brick_y, ball_x8, ball_y8;
    logic        brick_ov, centre_in, paddle_ov, descending, scan_last;

    assign vsync_fall = vsync_d && !bus.vsync;

    assign brick_x = 11'(BRICK_X0) + 11'(col_q) * 11'(BRICK_W);
    assign brick_y = 11'(BRICK_Y0) + 11'(row_q) * 11'(BRICK_H);
    assign ball_x8 = bx_l + 11'd8;
    assign ball_y8 = by_l + 11'd8;

    assign brick_ov = brick_map[idx_q]
                   && (ball_x8 > brick_x)
                   && (bx_l < brick_x + 11'(BRICK_W) + 11'd8)
                   && (ball_y8 > brick_y)
                   && (by_l < brick_y + 11'(BRICK_H) + 11'd8);

    // Ball centre within the brick's horizontal span means a top/bottom
    // face hit; anything else came in from the side.
    assign centre_in = (bx_l >= brick_x) && (bx_l < brick_x + 11'(BRICK_W));

    assign descending = by_l > prev_y;
    assign paddle_ov  = descending
                     && (ball_y8 >= 11'(PADDLE_Y))
                     && (ball_y8 < 11'(PADDLE_Y) + 11'(PADDLE_H) + 11'd10)
                     && (ball_x8 > px_l)
                     && (bx_l < px_l + 11'(PADDLE_W) + 11'd8);

    assign scan_last = (idx_q == 5'(ROWS * COLS - 1));

    // State register
    always_ff @(posedge pxl_clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vsync_fall) state_d = SCAN;
            SCAN:    if (scan_last)  state_d = PADDLE;
            PADDLE:  state_d = HIT;
            HIT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (new_game) state_d = IDLE;
    end

    assign fsm_state = state_q;

    // Datapath
    always_ff @(posedge pxl_clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d     <= 1'b0;
            bx_l        <= '0;
            by_l        <= '0;
            px_l        <= '0;
            prev_y      <= 11'd400;
            idx_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hit_found   <= 1'b0;
            hit_h       <= 1'b0;
            hit_idx     <= '0;
            paddle_hit  <= 1'b0;
            h_q         <= 1'b0;
            v_q         <= 1'b0;
            brick_map   <= 32'hFFFF_FFFF;
            bricks_left <= 6'd32;
            all_cleared <= 1'b0;
        end else begin
            vsync_d <= bus.vsync;
            h_q     <= 1'b0;
            v_q     <= 1'b0;
            if (new_game) begin
                // Aborts any scan in flight; pulses stay low.
                brick_map   <= 32'hFFFF_FFFF;
                bricks_left <= 6'd32;
                all_cleared <= 1'b0;
                hit_found   <= 1'b0;
                paddle_hit  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (vsync_fall) begin
                            bx_l       <= {1'b0, bus.ball_x};
                            by_l       <= {1'b0, bus.ball_y};
                            px_l       <= {1'b0, bus.paddle_x};
                            idx_q      <= '0;
                            col_q      <= '0;
                            row_q      <= '0;
                            hit_found  <= 1'b0;
                            paddle_hit <= 1'b0;
                        end
                    end
                    SCAN: begin
                        // Lowest index wins; later overlaps are ignored.
                        if (!hit_found && brick_ov) begin
                            hit_found <= 1'b1;
                            hit_idx   <= idx_q;
                            hit_h     <= !centre_in;
                        end
                        idx_q <= idx_q + 5'd1;
                        if (col_q == 5'(COLS - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 5'd1;
                        end else begin
                            col_q <= col_q + 5'd1;
                        end
                    end
                    PADDLE: begin
                        paddle_hit <= paddle_ov;
                        prev_y     <= by_l;
                    end
                    HIT: begin
                        if (hit_found) begin
                            h_q                <= hit_h;
                            v_q                <= !hit_h;
                            brick_map[hit_idx] <= 1'b0;
                            bricks_left        <= bricks_left - 6'd1;
                            if (bricks_left == 6'd1) all_cleared <= 1'b1;
                        end else if (paddle_hit) begin
                            v_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.h_collision = h_q;
    assign bus.v_collision = v_q;

`ifdef BRICK_SCORE_EN
    logic [7:0] score_q;
    logic [4:0] hit_row;
    logic [8:0] score_sum;

    // Row 0 is worth ROWS points, the bottom row 1.
    assign score_sum = {1'b0, score_q} + 9'(ROWS) - 9'(hit_row);

    always_ff @(posedge pxl_clk or negedge reset_n) begin
        if (!reset_n) begin
            score_q <= '0;
            hit_row <= '0;
        end else if (new_game) begin
            score_q <= '0;
        end else begin
            if (state_q == SCAN && !hit_found && brick_ov) hit_row <= row_q;
            if (state_q == HIT && hit_found)
                score_q <= (score_sum > 9'd255) ? 8'd255 : score_sum[7:0];
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_brick_collision.sv
// tb_brick_collision
//   Directed bench for brick_collision. A second instance with the paddle
//   raised to y=100 lets a brick and the paddle overlap in one frame.
module tb_brick_collision;

`ifdef BRICK_SCORE_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif

    // Clock / reset
    logic pxl_clk = 1'b0;
    logic reset_n;
    always #5 pxl_clk = ~pxl_clk;

    // Shared stimulus
    logic       vsync;
    logic       new_game;
    logic [9:0] ball_x, ball_y, paddle_x;

    brick_collision_if if1 ();
    brick_collision_if if2 ();

    assign if1.vsync = vsync;  assign if1.ball_x = ball_x;
    assign if1.ball_y = ball_y; assign if1.paddle_x = paddle_x;
    assign if2.vsync = vsync;  assign if2.ball_x = ball_x;
    assign if2.ball_y = ball_y; assign if2.paddle_x = paddle_x;

    logic [31:0] map1, map2;
    logic [7:0]  score1, score2;
    logic [5:0]  left1, left2;
    logic        clr1, clr2;
    logic [1:0]  st1, st2;

    brick_collision u_dut (
        .pxl_clk(pxl_clk), .reset_n(reset_n), .new_game(new_game), .bus(if1),
        .brick_map(map1), .score(score1), .bricks_left(left1),
        .all_cleared(clr1), .fsm_state(st1)
    );

    brick_collision #(.PADDLE_Y(100)) u_dut2 (
        .pxl_clk(pxl_clk), .reset_n(reset_n), .new_game(new_game), .bus(if2),
        .brick_map(map2), .score(score2), .bricks_left(left2),
        .all_cleared(clr2), .fsm_state(st2)
    );

    // Scoreboard counters
    int total = 0;
    int bad   = 0;

    // Per-frame observations
    int h1_n, v1_n, h2_n, v2_n, both_n, first_k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_new_game();
        @(negedge pxl_clk); new_game = 1'b1;
        @(negedge pxl_clk); new_game = 1'b0;
    endtask

    // Drives one vsync pulse, then watches 40 cycles after the falling
    // edge is sampled. first_k = 35 means the pulse sits between edge
    // N+34 and N+35. abort_at > 0 raises new_game for one cycle at that
    // point of the window.
    task automatic run_frame(input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] px, input int abort_at);
        h1_n = 0; v1_n = 0; h2_n = 0; v2_n = 0; both_n = 0; first_k = 0;
        @(negedge pxl_clk); vsync = 1'b1;
        @(negedge pxl_clk); vsync = 1'b0; ball_x = x; ball_y = y; paddle_x = px;
        for (int k = 1; k <= 40; k++) begin
            @(negedge pxl_clk);
            if ((if1.h_collision || if1.v_collision) && first_k == 0) first_k = k;
            h1_n += int'(if1.h_collision);
            v1_n += int'(if1.v_collision);
            h2_n += int'(if2.h_collision);
            v2_n += int'(if2.v_collision);
            if ((if1.h_collision && if1.v_collision) ||
                (if2.h_collision && if2.v_collision)) both_n++;
            new_game = (k == abort_at);
        end
        new_game = 1'b0;
    endtask

    initial begin
        int v_total;
        int pulses;
        reset_n = 1'b0; vsync = 1'b0; new_game = 1'b0;
        ball_x = '0; ball_y = '0; paddle_x = '0;
        repeat (3) @(negedge pxl_clk);
        reset_n = 1'b1;
        @(negedge pxl_clk);

        // Reset state
        chk("rst_map",   map1, 32'hFFFF_FFFF);
        chk("rst_left",  left1, 32);
        chk("rst_score", score1, 0);
        chk("rst_h",     if1.h_collision, 0);
        chk("rst_v",     if1.v_collision, 0);
        chk("rst_clr",   clr1, 0);
        chk("rst_state", st1, 0);

        // Top face of brick 0
        run_frame(10'd100, 10'd60, 10'd0, 0);
        chk("b0_latency", first_k, 35);
        chk("b0_v",       v1_n, 1);
        chk("b0_h",       h1_n, 0);
        chk("b0_map",     map1, 32'hFFFF_FFFE);
        chk("b0_left",    left1, 31);
        chk("b0_score",   score1, 4 * SC);

        do_new_game();
        chk("ng_map",   map1, 32'hFFFF_FFFF);
        chk("ng_left",  left1, 32);
        chk("ng_score", score1, 0);

        // Box edge exactly touching brick 0: strict compare, no hit
        run_frame(10'd56, 10'd56, 10'd0, 0);
        chk("touch_pulses", h1_n + v1_n, 0);
        chk("touch_map",    map1, 32'hFFFF_FFFF);

        // Left side of brick 0
        run_frame(10'd57, 10'd56, 10'd0, 0);
        chk("side_h",       h1_n, 1);
        chk("side_v",       v1_n, 0);
        chk("side_latency", first_k, 35);
        chk("side_map",     map1, 32'hFFFF_FFFE);
        chk("side_left",    left1, 31);

        // Paddle
        run_frame(10'd320, 10'd422, 10'd300, 0);
        chk("pad_above", h1_n + v1_n, 0);
        run_frame(10'd320, 10'd432, 10'd300, 0);
        chk("pad_v",     v1_n, 1);
        chk("pad_h",     h1_n, 0);
        chk("pad_map",   map1, 32'hFFFF_FFFE);
        run_frame(10'd320, 10'd442, 10'd300, 0);
        chk("pad_deep_v", v1_n, 1);
        run_frame(10'd320, 10'd432, 10'd300, 0);
        chk("pad_rising", h1_n + v1_n, 0);
        run_frame(10'd320, 10'd450, 10'd300, 0);
        chk("pad_below",  h1_n + v1_n, 0);

        // Brick and paddle in the same frame (second instance)
        do_new_game();
        run_frame(10'd600, 10'd20, 10'd0, 0);
        chk("pri_pre", h2_n + v2_n, 0);
        run_frame(10'd60, 10'd100, 10'd50, 0);
        chk("pri_h",    h2_n, 1);
        chk("pri_v",    v2_n, 0);
        chk("pri_both", both_n, 0);
        chk("pri_map",  map2, 32'hFFFE_FFFF);
        chk("pri_left", left2, 31);

        // Clear the whole wall, one brick per frame
        do_new_game();
        v_total = 0;
        for (int i = 0; i < 32; i++) begin
            run_frame(10'(96 + 64 * (i % 8)), 10'(56 + 16 * (i / 8)), 10'd0, 0);
            v_total += v1_n + h1_n;
            if (i == 30) begin
                chk("clr30_left", left1, 1);
                chk("clr30_flag", clr1, 0);
            end
        end
        chk("clr_pulses", v_total, 32);
        chk("clr_left",   left1, 0);
        chk("clr_map",    map1, 32'h0);
        chk("clr_flag",   clr1, 1);
        chk("clr_score",  score1, 80 * SC);

        // new_game during scan restores the wall, no pulse
        run_frame(10'd100, 10'd60, 10'd0, 10);
        chk("abort_pulses", h1_n + v1_n, 0);
        chk("abort_map",    map1, 32'hFFFF_FFFF);
        chk("abort_left",   left1, 32);
        chk("abort_flag",   clr1, 0);
        chk("abort_score",  score1, 0);
        run_frame(10'd100, 10'd60, 10'd0, 10);
        chk("abort2_pulses", h1_n + v1_n, 0);
        chk("abort2_map",    map1, 32'hFFFF_FFFF);
        // new_game while in HIT suppresses the pulse
        run_frame(10'd100, 10'd60, 10'd0, 34);
        chk("abort_hit_pulses", h1_n + v1_n, 0);
        chk("abort_hit_map",    map1, 32'hFFFF_FFFF);
        run_frame(10'd100, 10'd60, 10'd0, 0);
        chk("resume_v",   v1_n, 1);
        chk("resume_lat", first_k, 35);
        chk("resume_map", map1, 32'hFFFF_FFFE);

        // Reset mid-scan acts immediately
        @(negedge pxl_clk); vsync = 1'b1;
        @(negedge pxl_clk); vsync = 1'b0; ball_x = 10'd300; ball_y = 10'd60; paddle_x = 10'd0;
        repeat (5) @(negedge pxl_clk);
        chk("mid_state", st1, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_map",   map1, 32'hFFFF_FFFF);
        chk("arst_left",  left1, 32);
        chk("arst_state", st1, 0);
        chk("arst_v",     if1.v_collision, 0);
        @(negedge pxl_clk); reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge pxl_clk);
            pulses += int'(if1.h_collision) + int'(if1.v_collision);
        end
        chk("arst_no_pulse", pulses, 0);
        // prev_y back at 400, so y=432 counts as descending
        run_frame(10'd320, 10'd432, 10'd300, 0);
        chk("arst_prev_v", v1_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
